// File: rtl/dual_port_ram_pkg.sv
// Shared helpers for the byte-enabled dual-port RAM.
// merge_bytes() works on a wide container so one definition serves every
// DATA_WIDTH/BYTE_WIDTH combination; callers size-cast in and out.
package dual_port_ram_pkg;

    // Widest word the merge helper supports.
    localparam int MAX_W = 256;

    // Lane merge: bit i comes from new_w when its byte lane (i / bw) is enabled.
    function automatic logic [MAX_W-1:0] merge_bytes(
        input logic [MAX_W-1:0] old_w,
        input logic [MAX_W-1:0] new_w,
        input logic [MAX_W-1:0] be,
        input int               bw
    );
        logic [MAX_W-1:0] r;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = be[i / bw] ? new_w[i] : old_w[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Free-running read pipeline: LATENCY registered (valid, data) stages.
// Stage 0 is the combinational input. A data stage only loads when its
// incoming valid is set, so the output holds the last read between reads.
module ram_read_pipe #(
    parameter int  LATENCY = 1,
    parameter type dtype   = logic [31:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  dtype in_data,
    output logic out_valid,
    output dtype out_data
);

    typedef struct packed {
        logic valid;
        dtype data;
    } stage_t;

    stage_t pipe [1:LATENCY];

    // Shift valid every cycle; move data only behind a valid token.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= LATENCY; k++) pipe[k] <= '0;
        end else begin
            pipe[1].valid <= in_valid;
            if (in_valid) pipe[1].data <= in_data;
            for (int k = 2; k <= LATENCY; k++) begin
                pipe[k].valid <= pipe[k-1].valid;
                if (pipe[k-1].valid) pipe[k].data <= pipe[k-1].data;
            end
        end
    end

    assign out_valid = pipe[LATENCY].valid;
    assign out_data  = pipe[LATENCY].data;

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with byte write enables and per-port read latency.
// Own-port reads are write-first; on a same-address write collision port A
// wins per byte. Define DUAL_PORT_RAM_BYPASS_EN to forward the other port's
// same-cycle write into a read; otherwise the other port's bytes read old data.
module dual_port_ram_be
    import dual_port_ram_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int BYTE_WIDTH = 8,
    parameter  int SIZE       = 1024,
    parameter  int LATENCY    = 1,
    parameter  int LATENCY_A  = LATENCY,
    parameter  int LATENCY_B  = LATENCY,
    localparam int NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH,
    localparam int ADDR_WIDTH = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [NUM_BYTES-1:0]  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    output logic                  douta_valid,
    input  logic                  enb,
    input  logic [NUM_BYTES-1:0]  web,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  doutb_valid
);

    if (LATENCY_A < 1) begin : g_bad_lat_a
        $error("LATENCY_A must be >= 1");
    end
    if (LATENCY_B < 1) begin : g_bad_lat_b
        $error("LATENCY_B must be >= 1");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_bytes
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (SIZE < 2) begin : g_bad_size
        $error("SIZE must be >= 2");
    end
    if (DATA_WIDTH > MAX_W) begin : g_bad_width
        $error("DATA_WIDTH exceeds merge helper width");
    end

    typedef logic [DATA_WIDTH-1:0] word_t;

    function automatic word_t merge(word_t o, word_t n, logic [NUM_BYTES-1:0] be);
        return word_t'(merge_bytes(MAX_W'(o), MAX_W'(n), MAX_W'(be), BYTE_WIDTH));
    endfunction

    word_t mem [SIZE];

    logic  ina, inb, wr_a, wr_b, same, coll;
    word_t old_a, old_b, wr_word_a, wr_word_b, rd_a, rd_b;

    // Out-of-range addresses (non power-of-two SIZE) neither write nor read.
    assign ina   = int'(addra) < SIZE;
    assign inb   = int'(addrb) < SIZE;
    assign old_a = ina ? mem[addra] : '0;
    assign old_b = inb ? mem[addrb] : '0;
    assign wr_a  = ena && ina && (|wea);
    assign wr_b  = enb && inb && (|web);
    assign same  = addra == addrb;
    // Both ports writing one word: fold B's lanes into A's write, A on top.
    assign coll  = wr_a && wr_b && same;

    assign wr_word_a = merge(merge(old_a, dinb, coll ? web : '0), dina, wea);
    assign wr_word_b = merge(old_b, dinb, web);

`ifdef DUAL_PORT_RAM_BYPASS_EN
    logic fwd;
    // Any same-address pair with a live write forwards; the word both ports
    // see is the collided result, so A wins on overlapping lanes.
    assign fwd  = ena && enb && ina && inb && same;
    assign rd_a = ina ? merge(merge(old_a, dinb, fwd ? web : '0), dina, wea) : '0;
    assign rd_b = inb ? merge(merge(old_b, dinb, web), dina, fwd ? wea : '0) : '0;
`else
    assign rd_a = ina ? merge(old_a, dina, wea) : '0;
    assign rd_b = inb ? merge(old_b, dinb, web) : '0;
`endif

    // Memory array is never reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (wr_a)          mem[addra] <= wr_word_a;
            if (wr_b && !coll) mem[addrb] <= wr_word_b;
        end
    end

    ram_read_pipe #(.LATENCY(LATENCY_A), .dtype(word_t)) u_pipe_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ena),
        .in_data   (rd_a),
        .out_valid (douta_valid),
        .out_data  (douta)
    );

    ram_read_pipe #(.LATENCY(LATENCY_B), .dtype(word_t)) u_pipe_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (enb),
        .in_data   (rd_b),
        .out_valid (doutb_valid),
        .out_data  (doutb)
    );

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: directed table, hand sequences for reset,
// latency and bypass, then random traffic against a byte-level memory model.
module tb_dual_port_ram_be;

    localparam int DW = 32;
    localparam int BW = 8;
    localparam int NB = DW / BW;
    localparam int SZ = 1000;
    localparam int AW = 10;
    localparam int LA = 3;
    localparam int LB = 3;
`ifdef DUAL_PORT_RAM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ena = 1'b0, enb = 1'b0;
    logic [NB-1:0] wea = '0, web = '0;
    logic [AW-1:0] addra = '0, addrb = '0;
    logic [DW-1:0] dina = '0, dinb = '0;
    logic [DW-1:0] douta, doutb;
    logic          douta_valid, doutb_valid;

    always #5 clk = ~clk;

    dual_port_ram_be #(
        .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .SIZE(SZ),
        .LATENCY(1), .LATENCY_A(LA), .LATENCY_B(LB)
    ) dut (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta), .douta_valid(douta_valid),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
        .doutb(doutb), .doutb_valid(doutb_valid)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Reference model: word array plus per-port queues of (due cycle, data).
    logic [DW-1:0] mmem [SZ];
    typedef struct { int due; logic [DW-1:0] d; } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    logic [DW-1:0] last_a = '0, last_b = '0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] byt(input logic [DW-1:0] w, input int i);
        return BW'(w >> (BW * i));
    endfunction

    function automatic logic [DW-1:0] setbyt(input logic [DW-1:0] w, input int i, input logic [BW-1:0] b);
        logic [DW-1:0] m;
        m = DW'({BW{1'b1}}) << (BW * i);
        return (w & ~m) | (DW'(b) << (BW * i));
    endfunction

    // One clock: model the edge from current inputs, then check both ports.
    task automatic step();
        logic [DW-1:0] ra, rb, oa, ob;
        bit ia, ib, sm;
        exp_t e;
        if (!rst) begin
            qa.delete(); qb.delete();
            last_a = '0; last_b = '0;
        end else begin
            ia = int'(addra) < SZ;
            ib = int'(addrb) < SZ;
            sm = ena && enb && ia && ib && (addra == addrb);
            oa = ia ? mmem[addra] : '0;
            ob = ib ? mmem[addrb] : '0;
            ra = '0; rb = '0;
            for (int i = 0; i < NB; i++) begin
                if (!ia)                  ra = setbyt(ra, i, '0);
                else if (wea[i])          ra = setbyt(ra, i, byt(dina, i));
                else if (BYP && sm && web[i]) ra = setbyt(ra, i, byt(dinb, i));
                else                      ra = setbyt(ra, i, byt(oa, i));
                if (!ib)                  rb = setbyt(rb, i, '0);
                else if (BYP && sm && wea[i]) rb = setbyt(rb, i, byt(dina, i));
                else if (web[i])          rb = setbyt(rb, i, byt(dinb, i));
                else                      rb = setbyt(rb, i, byt(ob, i));
            end
            for (int i = 0; i < NB; i++) begin
                if (ena && ia && wea[i])
                    mmem[addra] = setbyt(mmem[addra], i, byt(dina, i));
                if (enb && ib && web[i] && !(ena && ia && wea[i] && addra == addrb))
                    mmem[addrb] = setbyt(mmem[addrb], i, byt(dinb, i));
            end
            if (ena) begin e.due = cyc + LA; e.d = ra; qa.push_back(e); end
            if (enb) begin e.due = cyc + LB; e.d = rb; qb.push_back(e); end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            e = qa.pop_front(); last_a = e.d; chkb("model_a_valid", douta_valid, 1'b1);
        end else chkb("model_a_valid", douta_valid, 1'b0);
        chk("model_a_data", douta, last_a);
        if (qb.size() > 0 && qb[0].due == cyc) begin
            e = qb.pop_front(); last_b = e.d; chkb("model_b_valid", doutb_valid, 1'b1);
        end else chkb("model_b_valid", doutb_valid, 1'b0);
        chk("model_b_data", doutb, last_b);
    endtask

    task automatic idle();
        ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    endtask

    task automatic wr_a(input int a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        idle(); ena = 1'b1; wea = be; addra = AW'(a); dina = d;
        step(); idle();
    endtask

    task automatic rd_a(input int a);
        idle(); ena = 1'b1; addra = AW'(a);
        step(); idle();
        repeat (LA - 1) step();
    endtask

    task automatic rd_b(input int a);
        idle(); enb = 1'b1; addrb = AW'(a);
        step(); idle();
        repeat (LB - 1) step();
    endtask

    typedef struct {
        logic [NB-1:0] wea; int aa; logic [DW-1:0] da;
        logic [NB-1:0] web; int ab; logic [DW-1:0] db;
        int ra; logic [DW-1:0] exp;
    } vec_t;

    function automatic vec_t mk(logic [NB-1:0] wa_, int aa_, logic [DW-1:0] da_,
                                logic [NB-1:0] wb_, int ab_, logic [DW-1:0] db_,
                                int ra_, logic [DW-1:0] ex_);
        vec_t v;
        v.wea = wa_; v.aa = aa_; v.da = da_;
        v.web = wb_; v.ab = ab_; v.db = db_;
        v.ra = ra_; v.exp = ex_;
        return v;
    endfunction

    function automatic logic [AW-1:0] pick();
        int r;
        r = $urandom_range(0, 23);
        return (r < 16) ? AW'(r) : AW'(980 + r);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt [9];
        vt[0] = mk(4'hF, 7,    32'h11223344, 4'h0, 0, 32'h0,        7,    32'h11223344);
        vt[1] = mk(4'h5, 7,    32'hAABBCCDD, 4'h0, 0, 32'h0,        7,    32'h00BB00DD);
        vt[2] = mk(4'h1, 3,    32'h000000AA, 4'h3, 3, 32'h0000BBBB, 3,    32'h0000BBAA);
        vt[3] = mk(4'hC, 4,    32'hCAFE0000, 4'h3, 4, 32'h0000F00D, 4,    32'hCAFEF00D);
        vt[4] = mk(4'hF, 6,    32'h01020304, 4'hF, 6, 32'h0A0B0C0D, 6,    32'h01020304);
        vt[5] = mk(4'h2, 8,    32'h00005500, 4'hF, 9, 32'h99999999, 8,    32'h00005500);
        vt[6] = mk(4'h0, 0,    32'h0,        4'h8, 10, 32'h77000000, 10,  32'h77000000);
        vt[7] = mk(4'hF, 1003, 32'hFFFFFFFF, 4'h0, 0, 32'h0,        1003, 32'h00000000);
        vt[8] = mk(4'hF, 999,  32'h5A5A5A5A, 4'h0, 0, 32'h0,        999,  32'h5A5A5A5A);

        // Reset held three cycles, then released: outputs idle at zero.
        idle(); rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("rst_douta", douta, '0);
        chk("rst_doutb", doutb, '0);
        chkb("rst_a_valid", douta_valid, 1'b0);
        chkb("rst_b_valid", doutb_valid, 1'b0);

        // Give every address the random phase touches a known value.
        for (int a = 0; a < 16; a++)    wr_a(a,   32'hC0DE0000 | DW'(a), 4'hF);
        for (int a = 996; a < 1000; a++) wr_a(a,  32'hC0DE0000 | DW'(a), 4'hF);

        // Memory survives a reset pulse.
        wr_a(5, 32'hDEADBEEF, 4'hF);
        rst = 1'b0; step(); rst = 1'b1;
        rd_a(5);
        chk("retain_after_rst", douta, 32'hDEADBEEF);

        // Byte enables with exact port-B latency.
        wr_a(7, 32'h11223344, 4'hF);
        wr_a(7, 32'hAABBCCDD, 4'h5);
        idle(); enb = 1'b1; addrb = AW'(7);
        step(); idle();
        for (int k = 1; k < LB; k++) begin
            chkb("be_early_valid", doutb_valid, 1'b0);
            step();
        end
        chkb("be_valid", doutb_valid, 1'b1);
        chk("be_data", doutb, 32'h11BB33DD);

        // Directed table: clear word, apply writes, read back through B.
        for (int n = 0; n < 9; n++) begin
            wr_a(vt[n].ra, '0, 4'hF);
            idle();
            ena = |vt[n].wea; wea = vt[n].wea; addra = AW'(vt[n].aa); dina = vt[n].da;
            enb = |vt[n].web; web = vt[n].web; addrb = AW'(vt[n].ab); dinb = vt[n].db;
            step(); idle();
            rd_b(vt[n].ra);
            chk($sformatf("table_%0d", n), doutb, vt[n].exp);
        end

        // Own-port write-first and cross-port behaviour.
        wr_a(9, 32'h0BAD0009, 4'hF);
        idle();
        ena = 1'b1; wea = 4'hF; addra = AW'(9); dina = 32'h12345678;
        enb = 1'b1; web = 4'h0; addrb = AW'(9);
        step(); idle();
        repeat (LA - 1) step();
        chk("write_first_a", douta, 32'h12345678);
        chk("cross_read_b", doutb, BYP ? 32'h12345678 : 32'h0BAD0009);

        // Back-to-back reads: one result per cycle, in order, after LA.
        for (int a = 0; a < 8; a++) wr_a(a, 32'hA0A00000 + DW'(a), 4'hF);
        repeat (LA) step();
        for (int i = 0; i < 8 + LA; i++) begin
            if (i < 8) begin idle(); ena = 1'b1; addra = AW'(i); end
            else idle();
            step();
            if (i >= LA - 1 && i < LA - 1 + 8) begin
                chkb("tp_valid", douta_valid, 1'b1);
                chk("tp_data", douta, 32'hA0A00000 + DW'(i - LA + 1));
            end else chkb("tp_valid_off", douta_valid, 1'b0);
        end

        // Reset one cycle after a read issues kills it in flight.
        idle(); enb = 1'b1; addrb = AW'(3);
        step(); idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 0; k < LB + 2; k++) begin
            step();
            chkb("midrst_b_valid", doutb_valid, 1'b0);
            chk("midrst_doutb", doutb, '0);
        end

        // Random traffic with collisions, partial writes and rare resets.
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 63) != 0);
            ena   = 1'($urandom_range(0, 1));
            enb   = 1'($urandom_range(0, 1));
            wea   = ($urandom_range(0, 2) == 0) ? '0 : NB'($urandom);
            web   = ($urandom_range(0, 2) == 0) ? '0 : NB'($urandom);
            addra = pick();
            addrb = ($urandom_range(0, 2) == 0) ? addra : pick();
            dina  = $urandom;
            dinb  = $urandom;
            step();
        end
        rst = 1'b1; idle();
        repeat (LA + LB) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
